// File: rtl/addertree_pkg.sv
// Width helpers and padding constant shared by the accumulating adder tree.
package addertree_pkg;

  localparam int unsigned PAD_VALUE = 0;

  function automatic int unsigned stage_num(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned tree_w(input int unsigned w, input int unsigned n);
    return w + stage_num(n);
  endfunction

  function automatic int unsigned out_w(input int unsigned w, input int unsigned n,
                                        input int unsigned ext);
    return tree_w(w, n) + ext;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the reduction tree: pairwise add of LANES inputs plus sideband delay.
module adder_tree_level #(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0][W-1:0]    lanes,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic                       in_mode,
  output logic [LANES/2-1:0][W-1:0]  sums,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       out_mode
);

  logic [LANES/2-1:0][W-1:0] pair;

  for (genvar g = 0; g < LANES / 2; g++) begin : g_pair
    assign pair[g] = lanes[2*g] + lanes[2*g+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sums      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mode  <= 1'b0;
    end else begin
      sums      <= pair;
      out_valid <= in_valid;
      out_last  <= in_last;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/acc_adder_tree.sv
// Pipelined reduction tree over INPUT_NUM operands with optional multi-beat accumulation.
module acc_adder_tree
  import addertree_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INPUT_NUM = 8,
  parameter bit          SIGNED    = 1'b1,
  parameter int unsigned ACC_EXT   = 8,
  parameter int unsigned STAGE_NUM = stage_num(INPUT_NUM),
  parameter int unsigned TREE_W    = tree_w(WIDTH, INPUT_NUM),
  parameter int unsigned OUT_W     = out_w(WIDTH, INPUT_NUM, ACC_EXT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic                              mode,
  input  logic [INPUT_NUM-1:0][WIDTH-1:0]   indata,
  output logic                              out_valid,
  output logic [OUT_W-1:0]                  res,
  output logic                              out_ovf
);

  localparam int unsigned LANES = 1 << STAGE_NUM;

  logic [LANES-1:0][TREE_W-1:0] ext_lanes;
  logic [LANES-1:0][TREE_W-1:0] lanes_q;
  logic                         valid_q, last_q, mode_q;

  for (genvar g = 0; g < LANES; g++) begin : g_ext
    if (g < INPUT_NUM) begin : g_op
      if (SIGNED) begin : g_s
        assign ext_lanes[g] = {{STAGE_NUM{indata[g][WIDTH-1]}}, indata[g]};
      end else begin : g_u
        assign ext_lanes[g] = {{STAGE_NUM{1'b0}}, indata[g]};
      end
    end else begin : g_pad
      assign ext_lanes[g] = TREE_W'(PAD_VALUE);
    end
  end

  // Input register gives the extra cycle ahead of the tree levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      lanes_q <= ext_lanes;
      valid_q <= in_valid;
      last_q  <= in_last | ~mode;
      mode_q  <= mode;
    end
  end

  for (genvar k = 0; k < STAGE_NUM; k++) begin : lvl
    localparam int unsigned NI = LANES >> k;
    logic [NI-1:0][TREE_W-1:0]   din;
    logic [NI/2-1:0][TREE_W-1:0] sum;
    logic                        vi, li, mi, v, l, m;

    if (k == 0) begin : g_src0
      assign din = lanes_q;
      assign vi  = valid_q;
      assign li  = last_q;
      assign mi  = mode_q;
    end else begin : g_srcn
      assign din = lvl[k-1].sum;
      assign vi  = lvl[k-1].v;
      assign li  = lvl[k-1].l;
      assign mi  = lvl[k-1].m;
    end

    adder_tree_level #(.LANES(NI), .W(TREE_W)) u_level (
      .clk       (clk),
      .rst       (rst),
      .lanes     (din),
      .in_valid  (vi),
      .in_last   (li),
      .in_mode   (mi),
      .sums      (sum),
      .out_valid (v),
      .out_last  (l),
      .out_mode  (m)
    );
  end

  logic [TREE_W-1:0] tree_out;
  logic              t_valid, close;
  logic [OUT_W-1:0]  acc;
  logic              open, ovf_acc, add_ovf;
  logic [OUT_W:0]    t_wide, a_wide, sum_wide;

  assign tree_out = lvl[STAGE_NUM-1].sum[0];
  assign t_valid  = lvl[STAGE_NUM-1].v;
  assign close    = lvl[STAGE_NUM-1].l | ~lvl[STAGE_NUM-1].m;

  always_comb begin
    t_wide   = {{(OUT_W + 1 - TREE_W){SIGNED & tree_out[TREE_W-1]}}, tree_out};
    a_wide   = open ? {SIGNED & acc[OUT_W-1], acc} : '0;
    sum_wide = a_wide + t_wide;
    add_ovf  = SIGNED ? (sum_wide[OUT_W] ^ sum_wide[OUT_W-1]) : sum_wide[OUT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      open      <= 1'b0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (t_valid) begin
        acc <= sum_wide[OUT_W-1:0];
        if (close) begin
          out_valid <= 1'b1;
          res       <= sum_wide[OUT_W-1:0];
          out_ovf   <= ovf_acc | add_ovf;
          open      <= 1'b0;
          ovf_acc   <= 1'b0;
        end else begin
          open    <= 1'b1;
          ovf_acc <= ovf_acc | add_ovf;
        end
      end
    end
  end

endmodule

// File: doc/acc_adder_tree.md
# acc_adder_tree

Pipelined, parametrised reduction tree that sums `INPUT_NUM` operands per beat, then optionally accumulates successive beat sums into one result. It sits behind the convolution MAC array: each beat carries one row of products, and the accumulator closes a kernel window. It supersedes the fixed power-of-two tree with the following additions:
- arbitrary operand count;
- signed or unsigned arithmetic;
- width growth without wrap inside the tree;
- valid tracking and multi-beat accumulation with overflow reporting.

## Interface
Parameters:
- `WIDTH`, 32, operand width.
- `INPUT_NUM`, 8, operands per beat; any value ≥1.
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned.
- `ACC_EXT`, 8, extra accumulator bits above the tree width.
- `STAGE_NUM` (derived), max(1, $clog2(INPUT_NUM)).
- `TREE_W` (derived), WIDTH+STAGE_NUM.
- `OUT_W` (derived), TREE_W+ACC_EXT.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: beat present on `indata`.
- `in_last` in 1: beat closes the current accumulation packet.
- `mode` in 1: 0 = per-beat sum, 1 = accumulate until `in_last`.
- `indata` in [INPUT_NUM-1:0][WIDTH-1:0]: operands.
- `out_valid` out 1: `res` holds a completed result.
- `res` out OUT_W: completed sum.
- `out_ovf` out 1: accumulation exceeded the `OUT_W` range during this packet.

## Operation
- Operands are zero-padded to 2^STAGE_NUM lanes. Padding value is 0 in both signed and unsigned modes.
- Each operand is extended to `TREE_W` bits:
  - sign-extended if `SIGNED`=1;
  - zero-extended if `SIGNED`=0.
- Tree level k (k = 0..STAGE_NUM-1):
  - adds pairs from level k;
  - registers 2^(STAGE_NUM-k-1) sums.
  - No tree sum can overflow `TREE_W`.
- `valid`, effective last and `mode` travel in a shift register aligned with the tree levels. The effective last flag is `in_last | ~mode`.
- Accumulator stage, acting on a valid tree output T:
  - accumulator closed (`open`=0): `acc <= ext(T)`;
  - accumulator open: `acc <= acc + ext(T)`.
  - Sums are computed in OUT_W+1 bits; `acc` keeps the low `OUT_W` bits, so the result wraps.
  - Overflow is detected per add:
    - signed: bits [OUT_W] and [OUT_W-1] of the wide sum differ;
    - unsigned: bit [OUT_W] is set.
  - `ovf_acc` is sticky over the packet.
  - If the beat is effective-last: `out_valid`=1, `res` = new acc, `out_ovf` = sticky | this-add overflow, then `open`<=0 and `ovf_acc`<=0.
  - Otherwise: `open`<=1 and `out_valid`=0.
- With no valid tree output, `acc`, `open` and `ovf_acc` hold, and `out_valid`=0. Bubbles inside a packet are legal.
- A `mode`=0 beat arriving while a packet is open is added in and closes the packet.
- No backpressure: a beat is accepted every cycle `in_valid`=1.

## Timing
- Latency: a beat sampled at edge t produces its accumulator update at edge t+STAGE_NUM+1. For a last beat, `out_valid` is high for the cycle after that edge. Example: INPUT_NUM=8 gives 4 cycles.
- Throughput: one beat per cycle; a result every cycle in `mode`=0.
- `out_valid` is a single-cycle pulse per packet. `res` and `out_ovf` hold their values until the next result.
- Reset values:
  - `out_valid`, `out_ovf` = 0; `res` = 0;
  - all valid/last/mode pipeline bits = 0;
  - `acc`, `open`, `ovf_acc` = 0;
  - tree data registers = 0.
- Reset mid-packet discards the partial sum and all in-flight beats. No output is produced for them.
- `rst` and `in_valid` both high on the same edge: `rst` wins and the beat is dropped.

## Structure
- Package `addertree_pkg`:
  - width helper functions `stage_num(n)`, `tree_w(w,n)`, `out_w(w,n,ext)`;
  - `localparam` for the padding value.
- Sub-module `adder_tree_level`, parametrised by lane count and width: registered pairwise add plus sideband pass-through. Instantiate it STAGE_NUM times in a generate loop.
- Accumulator and overflow logic stay in the top module.

## Test plan
- INPUT_NUM=8, SIGNED=1, `mode`=0, indata = 1..8 → `res`=36, `out_valid` pulses 4 cycles after input; 10 back-to-back beats give 10 consecutive results.
- INPUT_NUM=5 (padding), unsigned, all operands 0xFFFFFFFF → `res`=5×(2^32−1)=0x4_FFFF_FFFB, no tree wrap.
- `mode`=1, three beats each summing to −7, with bubbles of 0/2/1 cycles between them, `in_last` on the 3rd → single `out_valid`, `res`=−21 sign-extended to OUT_W, `out_ovf`=0.
- WIDTH=8, INPUT_NUM=2, ACC_EXT=0, signed (OUT_W=9), `mode`=1, beats (127,127) ×2 → `res` wraps to 508−512=−4, `out_ovf`=1; the next packet reports `out_ovf`=0.
- Reset asserted one cycle after the 2nd beat of an open packet, then a fresh 1-beat packet of all-ones (signed, INPUT_NUM=8) → only one result, `res`=−8, with no residue from the killed packet.
- `mode`=0 beat (sum 4) following two open `mode`=1 beats (sums 10, 20) → one result `res`=34.
